// File: rtl/systolic_pkg.sv
// ============================================================================
// systolic_pkg: shared state encoding and defaults for the systolic controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package systolic_pkg;

    localparam int DEFAULT_PE_LAT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } ctrl_state_t;

    function automatic int stream_cycles(input int n, input int lat);
        return (2 * n - 1) * lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/row_enable_shifter.sv
// ============================================================================
// row_enable_shifter: per-row PE enable mask, fills from the MSB and saturates
// Revision: 1.0
// ============================================================================
`default_nettype none

module row_enable_shifter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         clear,
    output logic [N-1:0] en
);

    logic [N-1:0] en_q;
    logic [N-1:0] en_d;

    // Stepping from all-zeros yields {1,0..0}, so the first step also seeds the mask.
    always_comb begin
        en_d = en_q;
        if (clear) begin
            en_d = '0;
        end else if (step) begin
            en_d = {1'b1, en_q[N-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= '0;
        end else begin
            en_q <= en_d;
        end
    end

    assign en = en_q;

endmodule

`default_nettype wire

// File: rtl/systolic_ctrl.sv
// ============================================================================
// systolic_ctrl: weight-load / stream / drain sequencer for an NxN systolic array
// Optional stall counter port enabled by SYSTOLIC_CTRL_PERF_CNT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int PE_LAT      = DEFAULT_PE_LAT,
    parameter int CNT_W       = $clog2((2 * MATRIX_SIZE - 1) * PE_LAT + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           general_enable,
    input  logic                           start,
    output logic                           busy,
    output logic [MATRIX_SIZE-1:0]         load_weight,
    output logic [$clog2(MATRIX_SIZE)-1:0] w_row,
    output logic [MATRIX_SIZE-1:0]         enable_mult,
    output logic                           result_valid,
    output logic [$clog2(MATRIX_SIZE)-1:0] result_row,
    output logic                           done
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                    stall_cycles
`endif
);

    localparam int ROW_W      = $clog2(MATRIX_SIZE);
    localparam int STREAM_LEN = stream_cycles(MATRIX_SIZE, PE_LAT);
    localparam int LAT_W      = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    localparam logic [CNT_W-1:0] ROWS_LAST   = CNT_W'(MATRIX_SIZE - 1);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(STREAM_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST    = LAT_W'(PE_LAT - 1);

    ctrl_state_t              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic                     rearm_q, rearm_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [MATRIX_SIZE-1:0]   lw_q, lw_d;
    logic [ROW_W-1:0]         wr_q, wr_d;
    logic                     rv_q, rv_d;
    logic [ROW_W-1:0]         rr_q, rr_d;

    logic                     shift_step;
    logic                     shift_clear;

    // Next state is computed as if the cycle advances; the registers only
    // take it when general_enable is high, which freezes everything on a stall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rearm_d = rearm_q;
        case (state_q)
            ST_IDLE: begin
                // One full IDLE cycle must pass after DONE before a start is honoured.
                if (rearm_q) begin
                    rearm_d = 1'b0;
                end else if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cnt_q == ROWS_LAST) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == ROWS_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rearm_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lat_d = '0;
        if ((state_q == ST_STREAM) && (state_d == ST_STREAM)) begin
            lat_d = (lat_q == LAT_LAST) ? '0 : lat_q + LAT_W'(1);
        end
    end

    assign shift_step  = general_enable && (state_d == ST_STREAM) && (lat_d == '0);
    assign shift_clear = general_enable && (state_d != ST_STREAM);

    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        lw_d   = '0;
        wr_d   = '0;
        rv_d   = 1'b0;
        rr_d   = '0;
        if (state_d == ST_LOAD) begin
            lw_d = MATRIX_SIZE'(1) << cnt_d;
            wr_d = ROW_W'(cnt_d);
        end
        if (state_d == ST_DRAIN) begin
            rv_d = 1'b1;
            rr_d = ROW_W'(cnt_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            rearm_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lw_q    <= '0;
            wr_q    <= '0;
            rv_q    <= 1'b0;
            rr_q    <= '0;
        end else if (general_enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            rearm_q <= rearm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lw_q    <= lw_d;
            wr_q    <= wr_d;
            rv_q    <= rv_d;
            rr_q    <= rr_d;
        end
    end

    row_enable_shifter #(
        .N (MATRIX_SIZE)
    ) u_row_enable_shifter (
        .clk   (clk),
        .reset (reset),
        .step  (shift_step),
        .clear (shift_clear),
        .en    (enable_mult)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign load_weight  = lw_q;
    assign w_row        = wr_q;
    assign result_valid = rv_q;
    assign result_row   = rr_q;

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic        accept;
    logic [31:0] stall_q;

    assign accept = general_enable && (state_q == ST_IDLE) && !rearm_q && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (busy_q && !general_enable && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter MATRIX_SIZE, default 2, array dimension N (rows = cols), N >= 2.
REQ-002 SHALL have parameter PE_LAT, default 4, cycles per row-enable step.
REQ-003 SHALL have parameter CNT_W, default $clog2((2*MATRIX_SIZE-1)*PE_LAT+1), width of the phase counter.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port general_enable, input, 1, global advance qualifier; low = stall.
REQ-007 SHALL have port start, input, 1, job request, sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1, job in progress.
REQ-009 SHALL have port load_weight, output, MATRIX_SIZE, one-hot weight-row load strobe.
REQ-010 SHALL have port w_row, output, $clog2(MATRIX_SIZE), index of the row being loaded.
REQ-011 SHALL have port enable_mult, output, MATRIX_SIZE, per-row PE enable (bit i = row i).
REQ-012 SHALL have port result_valid, output, 1, result row present on array outputs.
REQ-013 SHALL have port result_row, output, $clog2(MATRIX_SIZE), index of the valid result row.
REQ-014 SHALL have port done, output, 1, one-cycle job-complete pulse.

Function
REQ-015 SHALL implement the states IDLE, LOAD, STREAM, DRAIN and DONE, all outputs registered.
- IDLE->LOAD on start && general_enable; busy=1 from the next cycle.
- LOAD: N cycles; cycle k drives load_weight=1<<k and w_row=k; then ->STREAM.
- STREAM: (2N-1)*PE_LAT cycles; enable_mult starts at {1,0..0}; every PE_LAT cycles it becomes {1,enable_mult[N-1:1]}; it saturates at all-ones and holds; then ->DRAIN.
- DRAIN: N cycles, result_valid=1, result_row=0..N-1; enable_mult=0; then ->DONE.
- DONE: one cycle, done=1, busy=1; then ->IDLE, busy=0.
REQ-016 SHALL give start-sample-to-done latency N + (2N-1)*PE_LAT + N + 1 cycles.
REQ-017 SHALL, while general_enable=0, freeze state, counters and all outputs; a stalled cycle SHALL NOT count toward any phase length.
REQ-018 SHALL ignore start outside IDLE; no queuing.
REQ-019 SHALL let a start held high through DONE begin a new job only after one IDLE cycle.
REQ-020 SHALL drive load_weight, enable_mult and result_valid to zero in every state except their own.
REQ-021 SHALL never wrap the phase counter; it is cleared on each state entry.

Reset
REQ-022 SHALL, on reset (asynchronous, any state including mid-job), go to IDLE with busy=0, done=0, load_weight=0, enable_mult=0, result_valid=0, w_row=0, result_row=0 and counters=0.
REQ-023 SHALL, on reset release, require a fresh start; no resumption.

Configuration
REQ-024 SHALL, with SYSTOLIC_CTRL_PERF_CNT_EN defined, add a 32-bit output stall_cycles counting cycles with busy=1 && general_enable=0; cleared on start accept; saturates at all-ones.
REQ-025 SHALL, without SYSTOLIC_CTRL_PERF_CNT_EN, omit the port and the counter entirely.

Structure
REQ-026 SHALL take the state enum ctrl_state_t and the default PE_LAT constant from shared package systolic_pkg.
REQ-027 SHALL place the enable_mult shift/saturate logic in sub-module row_enable_shifter (inputs step, clear; output en[N-1:0]).

Verification (N=2, PE_LAT=4, start sampled at cycle 0)
REQ-028 SHALL pass the nominal job: load_weight=01 @1, 10 @2; enable_mult=10 @3-6, 11 @7-14; result_valid @15-16 with result_row 0,1; done @17; busy=0 @18.
REQ-029 SHALL pass a stall: general_enable low for 5 cycles during STREAM -> outputs frozen, done @22.
REQ-030 SHALL pass start during busy: start pulsed @8 -> ignored, single done @17.
REQ-031 SHALL pass reset mid-job: reset @10 -> all outputs 0 immediately; start @12 -> done @29.
REQ-032 SHALL pass back-to-back: start held high -> done @17, next LOAD strobe load_weight=01 @20.
REQ-033 SHALL pass perf counter (macro on): 3 stall cycles in LOAD -> stall_cycles=3 at done.
